// File: rtl/dmem_pkg.sv
// dmem_pkg: size codes, FSM states and size helper shared by the data-memory arbiter
package dmem_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  typedef enum logic {IDLE, ACCESS} state_t;
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return size == SZ_WORD ? 3'd4 : size == SZ_HALF ? 3'd2 : size == SZ_BYTE ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/dmem_access_check.sv
// dmem_access_check: flags invalid-size, misaligned and out-of-range accesses
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  output logic              err
);
  // one extra bit keeps addresses near the top of the space from wrapping to a legal end
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, addr} + (ADDR_W+1)'(size_bytes(size));
  assign err = (size == 2'b11) | (size == SZ_WORD & |addr[1:0]) | (size == SZ_HALF & addr[0])
             | (end_addr > (ADDR_W+1)'(MEM_BYTES));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-master arbiter issuing one-cycle data-memory accesses
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wd,
  input  logic [1:0]        m0_size,
  output logic              m0_gnt,
  output logic              m0_rsp_valid,
  output logic              m0_rsp_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wd,
  input  logic [1:0]        m1_size,
  output logic              m1_gnt,
  output logic              m1_rsp_valid,
  output logic              m1_rsp_err,
  output logic [31:0]       m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic [1:0]        mem_size,
  input  logic [31:0]       mem_rd
);
  state_t state, state_nx;
  logic any, win, last_win, sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0] sel_wd, rsp_data;
  logic [1:0] sel_size;
  logic cap_we, cap_id, cap_err;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0] cap_wd;
  logic [1:0] cap_size;
  always_comb begin
    any = m0_req | m1_req;
    win = m1_req & (~m0_req | ~last_win);
    sel_we = win ? m1_we : m0_we;
    sel_addr = win ? m1_addr : m0_addr;
    sel_wd = win ? m1_wd : m0_wd;
    sel_size = win ? m1_size : m0_size;
    m0_gnt = (state == IDLE) & m0_req & ~win;
    m1_gnt = (state == IDLE) & win;
    state_nx = (state == IDLE && any) ? ACCESS : IDLE;
    rsp_data = (cap_we | cap_err) ? 32'd0 : mem_rd;
  end
  dmem_access_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_check (
    .addr(sel_addr),
    .size(sel_size),
    .err (sel_err)
  );
  assign mem_we = (state == ACCESS) & cap_we & ~cap_err;
  assign mem_addr = cap_addr;
  assign mem_wd = cap_wd;
  assign mem_size = cap_size;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_win <= 1'b1;
      cap_we <= 1'b0;
      cap_id <= 1'b0;
      cap_err <= 1'b0;
      cap_addr <= '0;
      cap_wd <= '0;
      cap_size <= '0;
      m0_rsp_valid <= 1'b0;
      m0_rsp_err <= 1'b0;
      m0_rdata <= '0;
      m1_rsp_valid <= 1'b0;
      m1_rsp_err <= 1'b0;
      m1_rdata <= '0;
    end else begin
      state <= state_nx;
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
      if (state == IDLE && any) begin
        cap_we <= sel_we;
        cap_id <= win;
        cap_err <= sel_err;
        cap_addr <= sel_addr;
        cap_wd <= sel_wd;
        cap_size <= sel_size;
        last_win <= win;
      end
      if (state == ACCESS && cap_id) begin
        m1_rsp_valid <= 1'b1;
        m1_rsp_err <= cap_err;
        m1_rdata <= rsp_data;
      end
      if (state == ACCESS && !cap_id) begin
        m0_rsp_valid <= 1'b1;
        m0_rsp_err <= cap_err;
        m0_rdata <= rsp_data;
      end
    end
  end
endmodule
